// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the seven-segment scan controller
package seg7_pkg;

    localparam int N_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-high gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-high gfedcba segment pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_PATTERNS[nib];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 8-digit multiplexed seven-segment scanner with frame-aligned updates
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD_CYC = 2,
    parameter int BLANK_LZ  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    output logic [7:0]  atog,
    output logic [7:0]  seg_cs,
    output logic        upd_pend,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [31:0]   disp_val;
    logic [7:0]    disp_dp;
    logic [31:0]   pend_val;
    logic [7:0]    pend_dp;

    logic          slot_end;
    logic          frame_end;
    logic          guard;
    logic [3:0]    cur_nib;
    logic [6:0]    cur_seg;
    logic [7:0]    lz_blank;
    logic          zero_run;
    logic [7:0]    atog_nxt;
    logic [7:0]    seg_cs_nxt;

    assign slot_end   = en && (presc == PRESC_LAST);
    assign frame_end  = slot_end && (idx == 3'(N_DIGITS - 1));
    assign frame_done = frame_end;

    assign guard   = int'(presc) < GUARD_CYC;
    assign cur_nib = disp_val[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nib (cur_nib),
        .seg (cur_seg)
    );

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (disp_val[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_run && (BLANK_LZ != 0);
        end
    end

    always_comb begin
        atog_nxt   = SEG_OFF;
        seg_cs_nxt = SEG_OFF;
        if (en && !guard && !lz_blank[idx]) begin
            seg_cs_nxt = ~(8'd1 << idx);
            atog_nxt   = ~{disp_dp[idx], cur_seg};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            idx      <= '0;
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            upd_pend <= 1'b0;
            atog     <= SEG_OFF;
            seg_cs   <= SEG_OFF;
        end else begin
            if (!en) begin
                presc <= '0;
                idx   <= '0;
            end else if (slot_end) begin
                presc <= '0;
                idx   <= idx + 3'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            if (wr_en) begin
                pend_val <= wr_data;
                pend_dp  <= wr_dp;
            end

            // A write landing on the commit cycle goes straight to the display
            if (frame_end && wr_en) begin
                disp_val <= wr_data;
                disp_dp  <= wr_dp;
                upd_pend <= 1'b0;
            end else if (frame_end && upd_pend) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
                upd_pend <= 1'b0;
            end else if (wr_en) begin
                upd_pend <= 1'b1;
            end

            atog   <= atog_nxt;
            seg_cs <= seg_cs_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard bench for seg7_scan_ctrl against a frame-time reference model
module tb_seg7_scan_ctrl;

    localparam int D     = 4;
    localparam int G     = 1;
    localparam int FRAME = 8 * D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_dp = '0;

    logic [7:0]  atog0, seg_cs0, atog1, seg_cs1;
    logic        upd_pend0, frame_done0, upd_pend1, frame_done1;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.SCAN_DIV(D), .GUARD_CYC(G), .BLANK_LZ(0)) u_dut (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .atog(atog0), .seg_cs(seg_cs0), .upd_pend(upd_pend0), .frame_done(frame_done0)
    );

    seg7_scan_ctrl #(.SCAN_DIV(D), .GUARD_CYC(G), .BLANK_LZ(1)) u_dut_lz (
        .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .atog(atog1), .seg_cs(seg_cs1), .upd_pend(upd_pend1), .frame_done(frame_done1)
    );

    typedef struct {
        logic [7:0] a0, s0, a1, s1;
        logic       up, fd;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Reference state: time into the current frame, shown and pending values
    int          mt = 0;
    logic [31:0] shown = '0;
    logic [7:0]  sdp = '0;
    logic [31:0] pend = '0;
    logic [7:0]  pdp = '0;
    logic        pflag = 1'b0;

    function automatic logic [15:0] exp_disp(input logic e, input logic lz);
        int   dg;
        int   ph;
        logic [31:0] upper;
        logic [7:0]  a;
        ph    = mt % D;
        dg    = mt / D;
        upper = shown >> (4 * dg);
        if (!e || ph < G || (lz && dg >= 1 && upper == 0))
            return 16'hFFFF;
        a = seg_tab[upper & 32'hF] | (sdp[dg] ? 8'h80 : 8'h00);
        return {~a, ~(8'd1 << dg)};
    endfunction

    task automatic do_cycle(input logic r, input logic e, input logic w,
                            input logic [31:0] d, input logic [7:0] p);
        exp_t ex;
        logic [15:0] o0, o1;
        @(negedge clk);
        reset = r; en = e; wr_en = w; wr_data = d; wr_dp = p;
        if (r) begin
            mt = 0; shown = '0; sdp = '0; pend = '0; pdp = '0; pflag = 1'b0;
            ex = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
        end else begin
            o0 = exp_disp(e, 1'b0);
            o1 = exp_disp(e, 1'b1);
            if (e && mt == FRAME - 1) begin
                if (w) begin
                    shown = d; sdp = p; pflag = 1'b0;
                end else if (pflag) begin
                    shown = pend; sdp = pdp; pflag = 1'b0;
                end
            end else if (w) begin
                pend = d; pdp = p; pflag = 1'b1;
            end
            mt = e ? (mt + 1) % FRAME : 0;
            ex = '{o0[15:8], o0[7:0], o1[15:8], o1[7:0], pflag, e && (mt == FRAME - 1)};
        end
        sb.push_back(ex);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("atog", atog0, e.a0);
                chk("seg_cs", seg_cs0, e.s0);
                chk("upd_pend", {7'd0, upd_pend0}, {7'd0, e.up});
                chk("frame_done", {7'd0, frame_done0}, {7'd0, e.fd});
                chk("lz_atog", atog1, e.a1);
                chk("lz_seg_cs", seg_cs1, e.s1);
                chk("lz_upd_pend", {7'd0, upd_pend1}, {7'd0, e.up});
                chk("lz_frame_done", {7'd0, frame_done1}, {7'd0, e.fd});
            end
        end
    end

    initial begin : stimulus
        logic r, e, w;
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, '0, '0);
        idle(40);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h1234ABCD, 8'h01);
        idle(80);
        for (int i = 0; i < FRAME && mt != 2; i++) idle(1);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h1, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h2, 8'h00);
        idle(70);
        for (int i = 0; i < FRAME && mt != FRAME - 1; i++) idle(1);
        do_cycle(1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 8'h5A);
        idle(40);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h00000050, 8'h00);
        idle(70);
        do_cycle(1'b0, 1'b1, 1'b1, 32'h0, 8'h00);
        idle(70);
        for (int i = 0; i < FRAME && mt != 5; i++) idle(1);
        for (int i = 0; i < 5; i++)
            do_cycle(1'b0, 1'b0, i == 2, 32'h89ABCDEF, 8'hF0);
        idle(70);
        do_cycle(1'b0, 1'b1, 1'b1, 32'hDEAD0001, 8'h80);
        idle(3);
        do_cycle(1'b1, 1'b1, 1'b0, '0, '0);
        idle(40);
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 19) != 0);
            if (e && mt == FRAME - 1)
                w = $urandom_range(0, 1) == 1;
            else
                w = ($urandom_range(0, 29) == 0);
            do_cycle(r, e, w, $urandom >> $urandom_range(0, 31), 8'($urandom));
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
